reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 74 +++++++
 tb/tb_reg_file_sb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with link-register shift, write bypass, pending scoreboard and sweep clear.
module reg_file_sb #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int BYPASS     = 1,
  parameter int LINK_IDX   = 31,
  parameter int LINK_SHIFT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          ready,
  input  logic          reg_fileWr,
  input  logic [AW-1:0] Rw,
  input  logic [DW-1:0] busW,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic [DW-1:0] busA,
  output logic [DW-1:0] busB,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_rd,
  output logic          busy_a,
  output logic          busy_b
);
  localparam int DEPTH = 1 << AW;
  localparam logic IDLE  = 1'b0;
  localparam logic CLEAR = 1'b1;
  logic             state;
  logic [AW-1:0]    ptr;
  logic [DEPTH-1:0] pending;
  logic [DW-1:0]    mem [DEPTH];
  logic             idle, wr_ok, iss_ok, byp_a, byp_b;
  logic [DW-1:0]    wval;
  always_comb begin
    idle   = state == IDLE;
    wr_ok  = idle && reg_fileWr && Rw != '0;
    iss_ok = idle && iss_en && iss_rd != '0;
    wval   = Rw == AW'(LINK_IDX) ? DW'(busW << LINK_SHIFT) : busW;
    byp_a  = BYPASS != 0 && wr_ok && Rw == Ra;
    byp_b  = BYPASS != 0 && wr_ok && Rw == Rb;
    busA   = (!idle || Ra == '0) ? '0 : byp_a ? wval : mem[Ra];
    busB   = (!idle || Rb == '0) ? '0 : byp_b ? wval : mem[Rb];
    busy_a = idle && Ra != '0 && !byp_a && pending[Ra];
    busy_b = idle && Rb != '0 && !byp_b && pending[Rb];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      ptr     <= '0;
      pending <= '0;
      ready   <= 1'b0;
    end else if (state == CLEAR) begin
      pending[ptr] <= 1'b0;
      ptr          <= ptr + 1'b1;
      if (&ptr) begin
        state <= IDLE;
        ready <= 1'b1;
      end
    end else begin
      if (clr_req) begin
        state <= CLEAR;
        ptr   <= '0;
        ready <= 1'b0;
      end
      // issue is applied after the write so a same-index issue keeps the entry pending
      if (wr_ok) pending[Rw] <= 1'b0;
      if (iss_ok) pending[iss_rd] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!idle) mem[ptr] <= '0;
    else if (wr_ok) mem[Rw] <= wval;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vectors for reg_file_sb with hand-computed expectations.
module tb_reg_file_sb;
  logic        clk, rst_n, clr_req, ready, reg_fileWr, iss_en, busy_a, busy_b;
  logic [4:0]  Rw, Ra, Rb, iss_rd;
  logic [31:0] busW, busA, busB;
  int total = 0;
  int bad = 0;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
    .reg_fileWr(reg_fileWr), .Rw(Rw), .busW(busW), .Ra(Ra), .Rb(Rb),
    .busA(busA), .busB(busB), .iss_en(iss_en), .iss_rd(iss_rd),
    .busy_a(busy_a), .busy_b(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; reg_fileWr = 1'b0; iss_en = 1'b0;
    Rw = '0; Ra = '0; Rb = '0; iss_rd = '0; busW = '0;
    tick;
    tick;
    check("rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    Ra = 5'd5;
    #1;
    check("clr_ready_c0", 32'(ready), 32'd0);
    check("clr_busA", busA, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      tick;
      check($sformatf("rst_sweep_ready_c%0d", k), 32'(ready), 32'(k == 32));
    end
    for (int i = 1; i < 32; i++) begin
      Ra = 5'(i);
      #1;
      check($sformatf("init_r%0d", i), busA, 32'd0);
    end

    reg_fileWr = 1'b1; Rw = 5'd5; busW = 32'h1234_5678;
    tick;
    Rw = 5'd31; busW = 32'h0000_0100;
    tick;
    reg_fileWr = 1'b0; Ra = 5'd5; Rb = 5'd31;
    #1;
    check("r5", busA, 32'h1234_5678);
    check("r31_link", busB, 32'h0000_0400);
    reg_fileWr = 1'b1; Rw = 5'd0; busW = 32'hFFFF_FFFF; Ra = 5'd0;
    #1;
    check("r0_byp", busA, 32'd0);
    tick;
    reg_fileWr = 1'b0;
    #1;
    check("r0_after", busA, 32'd0);

    reg_fileWr = 1'b1; Rw = 5'd7; busW = 32'hA5A5_A5A5; Ra = 5'd7;
    #1;
    check("byp_a", busA, 32'hA5A5_A5A5);
    check("byp_busy", 32'(busy_a), 32'd0);
    tick;
    Rw = 5'd31; busW = 32'h0000_0001; Rb = 5'd31;
    #1;
    check("byp_link", busB, 32'h0000_0004);
    tick;
    reg_fileWr = 1'b0;
    #1;
    check("r7_held", busA, 32'hA5A5_A5A5);
    check("r31_new", busB, 32'h0000_0004);

    iss_en = 1'b1; iss_rd = 5'd9;
    tick;
    iss_en = 1'b0; Ra = 5'd9;
    #1;
    check("busy9_a", 32'(busy_a), 32'd1);
    tick;
    check("busy9_b", 32'(busy_a), 32'd1);
    reg_fileWr = 1'b1; Rw = 5'd9; busW = 32'h99;
    #1;
    check("busy9_wr", 32'(busy_a), 32'd0);
    check("r9_byp", busA, 32'h99);
    tick;
    reg_fileWr = 1'b0;
    #1;
    check("busy9_clr", 32'(busy_a), 32'd0);
    check("r9", busA, 32'h99);
    reg_fileWr = 1'b1; busW = 32'h77; iss_en = 1'b1; iss_rd = 5'd9;
    tick;
    reg_fileWr = 1'b0; iss_en = 1'b0;
    #1;
    check("busy9_iss_wins", 32'(busy_a), 32'd1);
    check("r9_77", busA, 32'h77);
    iss_en = 1'b1; iss_rd = 5'd0;
    tick;
    iss_en = 1'b0; Rb = 5'd3;
    #1;
    check("busy3_none", 32'(busy_b), 32'd0);

    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    reg_fileWr = 1'b1; Rw = 5'd12; busW = 32'hDEAD; iss_en = 1'b1; iss_rd = 5'd13;
    Ra = 5'd5; Rb = 5'd9;
    for (int k = 0; k < 32; k++) begin
      clr_req = (k == 5 || k == 6);
      #1;
      check($sformatf("clr_ready_c%0d", k), 32'(ready), 32'd0);
      if (k == 3) begin
        check("clr_busA0", busA, 32'd0);
        check("clr_busy_b0", 32'(busy_b), 32'd0);
      end
      tick;
    end
    clr_req = 1'b0; reg_fileWr = 1'b0; iss_en = 1'b0;
    #1;
    check("clr_ready_end", 32'(ready), 32'd1);
    for (int i = 1; i < 32; i++) begin
      Ra = 5'(i); Rb = 5'(i);
      #1;
      check($sformatf("clr_r%0d", i), busA, 32'd0);
      check($sformatf("clr_busy%0d", i), 32'(busy_b), 32'd0);
    end

    reg_fileWr = 1'b1; Rw = 5'd5; busW = 32'h5555;
    tick;
    reg_fileWr = 1'b0; Ra = 5'd5;
    #1;
    check("r5_reload", busA, 32'h5555);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    tick;
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick;
      check($sformatf("rst2_ready_c%0d", k), 32'(ready), 32'(k == 32));
    end
    check("r5_after_rst", busA, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
